lvds_word_aligner: RTL and testbench

- Parametrised successor to the fixed 7-lane x 8-bit ADC deserialiser back end.
- Takes raw parallel words from an LVDS SERDES receiver (LANES lanes, DESER bits per lane per frame).
- Applies a per-lane in-fabric bitslip and unpacks the result into SAMPLES ADC samples per frame.
- Runs a training FSM that finds each lane's slip offset against a known ADC test word, then flags lock or failure.
- Sits between the SERDES receiver and the sample FIFO/DSP, in the parallel-clock domain.

---
 rtl/lvds_word_aligner.sv | 177 +++++++++++++++++
 tb/tb_lvds_word_aligner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_word_aligner.sv
// LVDS word aligner: per-lane bitslip, sample unpack and a training FSM that
// searches each lane's slip offset against a known ADC test frame.
module lvds_word_aligner #(
  parameter int unsigned LANES         = 7,
  parameter int unsigned DESER         = 8,
  parameter int unsigned SAMPLE_WIDTH  = 14,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MATCH_CYCLES  = 64,
  parameter logic [(DESER/(SAMPLE_WIDTH/LANES))*SAMPLE_WIDTH-1:0] TRAIN_WORD =
    {14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0000}
) (
  input  logic                                         lvds_clk,
  input  logic                                         rstn,
  input  logic [LANES*DESER-1:0]                       rx_data,
  input  logic                                         train_start,
  output logic [(DESER/(SAMPLE_WIDTH/LANES))*SAMPLE_WIDTH-1:0] data_out,
  output logic                                         data_valid,
  output logic                                         aligned,
  output logic                                         align_fail,
  output logic                                         busy,
  output logic [LANES*$clog2(DESER)-1:0]               lane_offset,
  output logic [LANES-1:0]                             fail_lanes
);

  localparam int unsigned B       = SAMPLE_WIDTH / LANES;
  localparam int unsigned SAMPLES = DESER / B;
  localparam int unsigned OFFW    = $clog2(DESER);
  localparam int unsigned CNTW    = 16;
  localparam int unsigned DW      = SAMPLES * SAMPLE_WIDTH;

  localparam logic [OFFW:0]     DESER_L     = (OFFW+1)'(DESER);
  localparam logic [OFFW-1:0]   OFF_MAX     = OFFW'(DESER - 1);
  localparam logic [CNTW-1:0]   SETTLE_LAST = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [CNTW-1:0]   MATCH_LAST  = CNTW'(MATCH_CYCLES - 1);
  localparam logic [CNTW-1:0]   CNT_MAX     = {CNTW{1'b1}};

  if (((SAMPLE_WIDTH % LANES) != 0) || ((DESER % B) != 0)) begin : g_param_err
    $error("lvds_word_aligner: SAMPLE_WIDTH must divide by LANES and DESER by SAMPLE_WIDTH/LANES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL
  } state_t;

  state_t                          r_state, w_state_nxt;
  logic [CNTW-1:0]                 r_cnt, w_cnt_nxt;
  logic [LANES-1:0]                r_miss, w_miss_nxt;
  logic [LANES-1:0][OFFW-1:0]      r_offset, w_offset_nxt;
  logic [LANES-1:0]                r_fail, w_fail_nxt;
  logic                            w_busy_nxt, w_aligned_nxt, w_fail_flag_nxt, w_valid_nxt;

  logic [LANES-1:0][DESER-1:0]     r_cur, r_prev;
  logic [LANES-1:0][2*DESER-1:0]   w_cat;
  logic [LANES-1:0][OFFW:0]        w_shift;
  logic [LANES-1:0][DESER-1:0]     w_slip;
  logic [LANES-1:0][DESER-1:0]     w_exp;
  logic [LANES-1:0]                w_match;
  logic [LANES-1:0]                r_match;
  logic [DW-1:0]                   w_unpack;

  // Bitslip: s = 0 passes cur through, larger s pulls in bits from prev.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_cat[l]   = {r_cur[l], r_prev[l]};
    assign w_shift[l] = DESER_L - {1'b0, r_offset[l]};
    assign w_slip[l]  = DESER'(w_cat[l] >> w_shift[l]);
    assign w_match[l] = (w_slip[l] == w_exp[l]);
  end

  // Sample k takes B bits per lane, lanes MSB-first, lane bit B*k first within a lane.
  for (genvar k = 0; k < SAMPLES; k++) begin : g_smp
    for (genvar l = 0; l < LANES; l++) begin : g_ln
      for (genvar j = 0; j < B; j++) begin : g_bit
        localparam int unsigned PS = k*SAMPLE_WIDTH + l*B + (B - 1 - j);
        localparam int unsigned PW = B*k + j;
        assign w_unpack[PS]  = w_slip[l][PW];
        assign w_exp[l][PW]  = TRAIN_WORD[PS];
      end
    end
  end

  always_ff @(posedge lvds_clk or negedge rstn) begin : p_pipe
    if (!rstn) begin
      r_cur    <= '0;
      r_prev   <= '0;
      r_match  <= '0;
      data_out <= '0;
    end else begin
      r_cur    <= rx_data;
      r_prev   <= r_cur;
      r_match  <= w_match;
      data_out <= w_unpack;
    end
  end

  always_ff @(posedge lvds_clk or negedge rstn) begin : p_state
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_miss     <= '0;
      r_offset   <= '0;
      r_fail     <= '0;
      busy       <= 1'b0;
      aligned    <= 1'b0;
      align_fail <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_miss     <= w_miss_nxt;
      r_offset   <= w_offset_nxt;
      r_fail     <= w_fail_nxt;
      busy       <= w_busy_nxt;
      aligned    <= w_aligned_nxt;
      align_fail <= w_fail_flag_nxt;
      data_valid <= w_valid_nxt;
    end
  end

  always_comb begin : p_next
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_miss_nxt   = r_miss;
    w_offset_nxt = r_offset;
    w_fail_nxt   = r_fail;

    unique case (r_state)
      S_SETTLE: begin
        if (r_cnt >= SETTLE_LAST) begin
          w_state_nxt = S_CHECK;
          w_cnt_nxt   = '0;
          w_miss_nxt  = '0;
        end else begin
          w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNTW'(1);
        end
      end
      S_CHECK: begin
        w_miss_nxt = r_miss | ~r_match;
        if (r_cnt >= MATCH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (|w_miss_nxt) ? S_SLIP : S_LOCKED;
        end else begin
          w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNTW'(1);
        end
      end
      S_SLIP: begin
        // Only missing lanes advance; a lane out of offsets is marked failed.
        for (int l = 0; l < LANES; l++) begin
          if (r_miss[l]) begin
            if (r_offset[l] != OFF_MAX) w_offset_nxt[l] = r_offset[l] + OFFW'(1);
            else                        w_fail_nxt[l]   = 1'b1;
          end
        end
        w_cnt_nxt   = '0;
        w_state_nxt = (|w_fail_nxt) ? S_FAIL : S_SETTLE;
      end
      default: ;
    endcase

    if (train_start) begin
      w_state_nxt  = S_SETTLE;
      w_cnt_nxt    = '0;
      w_miss_nxt   = '0;
      w_offset_nxt = '0;
      w_fail_nxt   = '0;
    end

    w_busy_nxt      = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CHECK) ||
                      (w_state_nxt == S_SLIP);
    w_aligned_nxt   = (w_state_nxt == S_LOCKED);
    w_fail_flag_nxt = (w_state_nxt == S_FAIL);
    w_valid_nxt     = (r_state == S_LOCKED) && (w_state_nxt == S_LOCKED);
  end

  assign lane_offset = r_offset;
  assign fail_lanes  = r_fail;

endmodule

// File: tb/tb_lvds_word_aligner.sv
// Self-checking bench for lvds_word_aligner: directed training scenarios plus
// random data streams compared against a bit-level reference of the alignment rules.
module tb_lvds_word_aligner;

  localparam logic [55:0] TRAIN = {14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0000};

  logic        lvds_clk    = 1'b0;
  logic        rstn        = 1'b1;
  logic [55:0] rx_data     = '0;
  logic        train_start = 1'b0;
  logic [55:0] data_out;
  logic        data_valid, aligned, align_fail, busy;
  logic [20:0] lane_offset;
  logic [6:0]  fail_lanes;

  int checks   = 0;
  int failures = 0;

  always #5 lvds_clk = ~lvds_clk;

  lvds_word_aligner dut (
    .lvds_clk    (lvds_clk),
    .rstn        (rstn),
    .rx_data     (rx_data),
    .train_start (train_start),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .aligned     (aligned),
    .align_fail  (align_fail),
    .busy        (busy),
    .lane_offset (lane_offset),
    .fail_lanes  (fail_lanes)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge lvds_clk);
    #1;
  endtask

  // Lane words whose unpacking reproduces TRAIN, walking each sample MSB-first.
  function automatic logic [55:0] exp_lanes();
    logic [55:0] e;
    int b;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      b = 13;
      for (int l = 6; l >= 0; l--)
        for (int j = 0; j < 2; j++) begin
          e[l*8 + 2*k + j] = TRAIN[k*14 + b];
          b--;
        end
    end
    return e;
  endfunction

  function automatic logic [55:0] unpack_m(input logic [55:0] w);
    logic [55:0] o;
    logic [13:0] acc;
    o = '0;
    for (int k = 0; k < 4; k++) begin
      acc = '0;
      for (int l = 6; l >= 0; l--)
        for (int j = 0; j < 2; j++)
          acc = {acc[12:0], w[l*8 + 2*k + j]};
      o[k*14 +: 14] = acc;
    end
    return o;
  endfunction

  function automatic logic [55:0] slip_m(input logic [55:0] c, input logic [55:0] p,
                                         input logic [20:0] offs);
    logic [55:0] o;
    logic [15:0] cat;
    int s;
    o = '0;
    for (int l = 0; l < 7; l++) begin
      s   = int'(offs[l*3 +: 3]);
      cat = {c[l*8 +: 8], p[l*8 +: 8]};
      cat = cat >> (8 - s);
      o[l*8 +: 8] = cat[7:0];
    end
    return o;
  endfunction

  // A lane arriving d bits late is its pattern rotated right by d.
  function automatic logic [55:0] delayed(input logic [55:0] e, input logic [20:0] d);
    logic [55:0] o;
    logic [15:0] cat;
    for (int l = 0; l < 7; l++) begin
      cat = {e[l*8 +: 8], e[l*8 +: 8]};
      cat = cat >> int'(d[l*3 +: 3]);
      o[l*8 +: 8] = cat[7:0];
    end
    return o;
  endfunction

  task automatic pulse_start();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!(aligned || align_fail) && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic random_stream(input string tag, input logic [20:0] offs, input int n);
    logic [55:0] x [$];
    logic [55:0] v;
    for (int i = 0; i < n; i++) begin
      v = 56'({$urandom(), $urandom()});
      x.push_back(v);
      rx_data = v;
      tick();
      if (i >= 2) check(tag, data_out, unpack_m(slip_m(x[i-1], x[i-2], offs)));
    end
  endtask

  initial begin
    logic [55:0] e;
    logic [20:0] d;
    int cyc;
    e = exp_lanes();

    // Reset state
    #2 rstn = 1'b0;
    #2;
    check("rst_data_out", data_out, 0);
    check("rst_flags", {aligned, align_fail, busy, data_valid}, 0);
    check("rst_offset", lane_offset, 0);
    check("rst_fail_lanes", fail_lanes, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Mapping: lane 6 = 8'h03 lands in the two MSBs of sample 0
    rx_data = 56'h03 << 48;
    tick();
    tick();
    check("map_lane6", data_out, 56'h3000);
    random_stream("map_random", 21'd0, 20);

    // Pre-aligned lanes
    rx_data = e;
    tick();
    pulse_start();
    check("pre_busy", busy, 1);
    wait_done(400, cyc);
    check("pre_lock_latency_ok", (cyc >= 72 && cyc <= 76), 1);
    check("pre_aligned", aligned, 1);
    check("pre_offset", lane_offset, 0);
    check("pre_data", data_out, TRAIN);
    tick();
    check("pre_valid", {data_valid, busy}, 2'b10);

    // Lane 2 delayed by three bits
    d = 21'd3 << 6;
    rx_data = delayed(e, d);
    pulse_start();
    check("l2_aligned_cleared", {aligned, busy}, 2'b01);
    wait_done(2000, cyc);
    check("l2_aligned", {aligned, align_fail}, 2'b10);
    check("l2_offset", lane_offset, d);
    check("l2_data", data_out, TRAIN);

    // Retrain while locked
    tick();
    pulse_start();
    check("rt_drop", {aligned, busy, data_valid}, 3'b010);
    check("rt_offset_zeroed", lane_offset, 0);
    wait_done(2000, cyc);
    check("rt_aligned", aligned, 1);
    check("rt_offset", lane_offset, d);
    check("rt_data", data_out, TRAIN);

    // Lane 0 stuck low exhausts its offsets
    rx_data = e & ~56'hFF;
    pulse_start();
    wait_done(3000, cyc);
    check("f_fail", {align_fail, aligned, busy, data_valid}, 4'b1000);
    check("f_fail_lanes", fail_lanes, 7'h01);
    check("f_offset", lane_offset, 21'd7);

    // Random per-lane delays, then random data through the locked slips
    d = '0;
    for (int l = 0; l < 7; l++) d[l*3 +: 3] = 3'($urandom_range(0, 7));
    rx_data = delayed(e, d);
    pulse_start();
    check("rd_fail_cleared", {align_fail, fail_lanes}, 0);
    wait_done(3000, cyc);
    check("rd_aligned", aligned, 1);
    check("rd_offset", lane_offset, d);
    check("rd_data", data_out, TRAIN);
    random_stream("rd_stream", d, 24);
    check("rd_valid", data_valid, 1);

    // Asynchronous reset in the middle of CHECK
    rx_data = e;
    pulse_start();
    for (int i = 0; i < 30; i++) tick();
    check("mid_busy", busy, 1);
    #2;
    rstn = 1'b0;
    rx_data = '0;
    #1;
    check("mid_rst_data", data_out, 0);
    check("mid_rst_flags", {aligned, align_fail, busy, data_valid}, 0);
    check("mid_rst_offset", {lane_offset, fail_lanes}, 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_flags", {aligned, align_fail, busy, data_valid}, 0);
    check("post_rst_data", data_out, 0);
    check("post_rst_offset", {lane_offset, fail_lanes}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
